// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline encodings for result kinds, forwarding selects and Tuse,
// plus the compare helpers used by the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_DM  = 2'd1,
    RES_PC  = 2'd2
  } res_e;

  localparam logic [1:0] TUSE_NEVER = 2'd3;

  // D and E stage forwarding selects share one numeric encoding.
  localparam logic [3:0] FWD_NONE  = 4'd0;
  localparam logic [3:0] FWD_M_ALU = 4'd1;
  localparam logic [3:0] FWD_M_PC  = 4'd2;
  localparam logic [3:0] FWD_W_ALU = 4'd3;
  localparam logic [3:0] FWD_W_DM  = 4'd4;
  localparam logic [3:0] FWD_W_PC  = 4'd5;

  localparam logic [3:0] M_D_ALU = FWD_M_ALU;
  localparam logic [3:0] M_D_PC  = FWD_M_PC;
  localparam logic [3:0] W_D_ALU = FWD_W_ALU;
  localparam logic [3:0] W_D_DM  = FWD_W_DM;
  localparam logic [3:0] W_D_PC  = FWD_W_PC;

  localparam logic [3:0] M_E_ALU = FWD_M_ALU;
  localparam logic [3:0] M_E_PC  = FWD_M_PC;
  localparam logic [3:0] W_E_ALU = FWD_W_ALU;
  localparam logic [3:0] W_E_DM  = FWD_W_DM;
  localparam logic [3:0] W_E_PC  = FWD_W_PC;

  localparam logic [3:0] W_M_ALU = 4'd1;
  localparam logic [3:0] W_M_DM  = 4'd2;
  localparam logic [3:0] W_M_PC  = 4'd3;

  // Select for a D- or E-stage source: M has priority over W, and M is only
  // usable once its result is ready (tnew == 0). Register 0 never matches.
  function automatic logic [3:0] fwd_sel_de(
    input logic [4:0] src,
    input logic [4:0] a3_m,
    input logic [1:0] tnew_m,
    input logic [1:0] res_m,
    input logic [4:0] a3_w,
    input logic [1:0] res_w
  );
    logic [3:0] sel;
    sel = FWD_NONE;
    if (src != 5'd0 && src == a3_m && tnew_m == 2'd0 &&
        (res_m == RES_ALU || res_m == RES_PC)) begin
      sel = (res_m == RES_PC) ? FWD_M_PC : FWD_M_ALU;
    end else if (src != 5'd0 && src == a3_w) begin
      case (res_w)
        RES_ALU: sel = FWD_W_ALU;
        RES_DM:  sel = FWD_W_DM;
        RES_PC:  sel = FWD_W_PC;
        default: sel = FWD_NONE;
      endcase
    end
    return sel;
  endfunction

  // Store-data select in M: only W can supply it.
  function automatic logic [3:0] fwd_sel_m(
    input logic [4:0] rt_m,
    input logic [4:0] a3_w,
    input logic [1:0] res_w
  );
    logic [3:0] sel;
    sel = FWD_NONE;
    if (rt_m != 5'd0 && rt_m == a3_w) begin
      case (res_w)
        RES_ALU: sel = W_M_ALU;
        RES_DM:  sel = W_M_DM;
        RES_PC:  sel = W_M_PC;
        default: sel = FWD_NONE;
      endcase
    end
    return sel;
  endfunction

  // A source hazards against a producer when it is needed before it is ready.
  function automatic logic data_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (src == a3) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy_cnt.sv
// Multiply/divide busy counter: loaded on a start in E, counts down to zero,
// and reports the HI/LO unit busy while non-zero.
module md_busy_cnt
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  input  logic md_div_i,
  output logic md_busy_o
);

  localparam logic [3:0] CNT_MULT = 4'(MULT_CYC);
  localparam logic [3:0] CNT_DIV  = 4'(DIV_CYC);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start_i) begin
      cnt_d = md_div_i ? CNT_DIV : CNT_MULT;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Central hazard controller for the 5-stage pipeline: Tuse/Tnew stall
// detection, forwarding mux selects and the mult/div busy tracker.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic       md_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] a3_E,
  input  logic [1:0] tnew_E,
  input  logic [1:0] res_E,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic [4:0] rt_M,
  input  logic [4:0] a3_M,
  input  logic [1:0] tnew_M,
  input  logic [1:0] res_M,
  input  logic [4:0] a3_W,
  input  logic [1:0] res_W,
  output logic [3:0] mfcmp1_sel,
  output logic [3:0] mfcmp2_sel,
  output logic [3:0] mfalua_sel,
  output logic [3:0] mfalub_sel,
  output logic [3:0] mfdm_sel,
  output logic       en_pc,
  output logic       en_fd,
  output logic       clr_de,
  output logic       md_busy
);

  logic stall_rs;
  logic stall_rt;
  logic stall_data;
  logic stall_md;
  logic stall;

  // res_E is not needed: nothing forwards out of E, and Tnew already
  // captures when its result becomes available.
  logic unused_res_e;
  assign unused_res_e = ^res_E;

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (md_start_E),
    .md_div_i   (md_div_E),
    .md_busy_o  (md_busy)
  );

  assign mfcmp1_sel = fwd_sel_de(rs_D, a3_M, tnew_M, res_M, a3_W, res_W);
  assign mfcmp2_sel = fwd_sel_de(rt_D, a3_M, tnew_M, res_M, a3_W, res_W);
  assign mfalua_sel = fwd_sel_de(rs_E, a3_M, tnew_M, res_M, a3_W, res_W);
  assign mfalub_sel = fwd_sel_de(rt_E, a3_M, tnew_M, res_M, a3_W, res_W);
  assign mfdm_sel   = fwd_sel_m(rt_M, a3_W, res_W);

  always_comb begin
    stall_rs   = data_hazard(rs_D, tuse_rs_D, a3_E, tnew_E) ||
                 data_hazard(rs_D, tuse_rs_D, a3_M, tnew_M);
    stall_rt   = data_hazard(rt_D, tuse_rt_D, a3_E, tnew_E) ||
                 data_hazard(rt_D, tuse_rt_D, a3_M, tnew_M);
    stall_data = stall_rs || stall_rt;
    // A start in E counts as busy already, before the counter loads.
    stall_md   = md_D && (md_busy || md_start_E);
    stall      = stall_data || stall_md;
  end

  assign en_pc  = ~stall;
  assign en_fd  = ~stall;
  assign clr_de = stall;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: expectations are queued as stimulus is
// applied and popped against the DUT outputs mid-cycle.
module tb_hazard_fwd_ctrl;

  localparam logic [1:0] R_ALU = 2'd0;
  localparam logic [1:0] R_DM  = 2'd1;
  localparam logic [1:0] R_PC  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, a3_E, rt_M, a3_M, a3_W;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, res_E, tnew_M, res_M, res_W;
  logic       md_D, md_start_E, md_div_E;
  logic [3:0] mfcmp1_sel, mfcmp2_sel, mfalua_sel, mfalub_sel, mfdm_sel;
  logic       en_pc, en_fd, clr_de, md_busy;

  typedef struct {
    logic [3:0] c1, c2, a, b, dm;
    logic       stall, busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_D(md_D),
    .rs_E(rs_E), .rt_E(rt_E), .a3_E(a3_E), .tnew_E(tnew_E), .res_E(res_E),
    .md_start_E(md_start_E), .md_div_E(md_div_E),
    .rt_M(rt_M), .a3_M(a3_M), .tnew_M(tnew_M), .res_M(res_M),
    .a3_W(a3_W), .res_W(res_W),
    .mfcmp1_sel(mfcmp1_sel), .mfcmp2_sel(mfcmp2_sel),
    .mfalua_sel(mfalua_sel), .mfalub_sel(mfalub_sel), .mfdm_sel(mfdm_sel),
    .en_pc(en_pc), .en_fd(en_fd), .clr_de(clr_de), .md_busy(md_busy)
  );

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0; md_D = 0;
    rs_E = 0; rt_E = 0; a3_E = 0; tnew_E = 0; res_E = R_ALU;
    md_start_E = 0; md_div_E = 0;
    rt_M = 0; a3_M = 0; tnew_M = 0; res_M = R_ALU;
    a3_W = 0; res_W = R_ALU;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] c1, input logic [3:0] c2,
                            input logic [3:0] a, input logic [3:0] b, input logic [3:0] dm,
                            input logic stall, input logic busy);
    exp_t e;
    e.c1 = c1; e.c2 = c2; e.a = a; e.b = b; e.dm = dm;
    e.stall = stall; e.busy = busy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".cmp1"},   mfcmp1_sel, e.c1);
    check({t, ".cmp2"},   mfcmp2_sel, e.c2);
    check({t, ".alua"},   mfalua_sel, e.a);
    check({t, ".alub"},   mfalub_sel, e.b);
    check({t, ".dm"},     mfdm_sel,   e.dm);
    check({t, ".en_pc"},  {3'd0, en_pc},   {3'd0, ~e.stall});
    check({t, ".en_fd"},  {3'd0, en_fd},   {3'd0, ~e.stall});
    check({t, ".clr_de"}, {3'd0, clr_de},  {3'd0, e.stall});
    check({t, ".busy"},   {3'd0, md_busy}, {3'd0, e.busy});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    expect_out("in_reset", 0, 0, 0, 0, 0, 0, 0); pop_check();
    #5 rst_n = 1'b1;
    next_cycle();
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0); sample();

    // E-stage forwarding, M over W
    next_cycle();
    rs_E = 8; a3_M = 8; tnew_M = 0; res_M = R_ALU; a3_W = 8; res_W = R_DM;
    expect_out("e_m_prio", 0, 0, 1, 0, 0, 0, 0); sample();
    next_cycle();
    a3_M = 0; rt_E = 8;
    expect_out("e_w_dm", 0, 0, 4, 4, 0, 0, 0); sample();
    next_cycle();
    a3_M = 8; res_M = R_PC;
    expect_out("e_m_pc", 0, 0, 2, 2, 0, 0, 0); sample();
    next_cycle();
    tnew_M = 1; rs_D = 8; tuse_rs_D = 0; rt_D = 8; tuse_rt_D = 1;
    expect_out("m_not_ready", 4, 4, 4, 4, 0, 1, 0); sample();
    next_cycle();
    tuse_rs_D = 1;
    expect_out("tuse_eq_tnew", 4, 4, 4, 4, 0, 0, 0); sample();
    next_cycle();
    a3_M = 0; res_W = R_ALU;
    expect_out("w_alu", 3, 3, 3, 3, 0, 0, 0); sample();
    next_cycle();
    res_W = R_PC;
    expect_out("w_pc", 5, 5, 5, 5, 0, 0, 0); sample();

    // load-use stall against E
    next_cycle();
    clear_inputs();
    a3_E = 9; tnew_E = 2; rs_D = 9; tuse_rs_D = 0;
    expect_out("lw_beq", 0, 0, 0, 0, 0, 1, 0); sample();
    next_cycle();
    rs_D = 0;
    expect_out("lw_rs0", 0, 0, 0, 0, 0, 0, 0); sample();
    next_cycle();
    rs_D = 9; tuse_rs_D = 2;
    expect_out("lw_tuse2", 0, 0, 0, 0, 0, 0, 0); sample();
    next_cycle();
    tuse_rs_D = 1;
    expect_out("lw_tuse1", 0, 0, 0, 0, 0, 1, 0); sample();
    next_cycle();
    rs_D = 0; tuse_rs_D = 0; rt_D = 9; tuse_rt_D = 2'd3;
    expect_out("lw_never", 0, 0, 0, 0, 0, 0, 0); sample();
    next_cycle();
    a3_E = 0; rt_D = 0; tuse_rt_D = 0;
    expect_out("zero_dest", 0, 0, 0, 0, 0, 0, 0); sample();

    // mult: busy for 5 cycles, no HI/LO user in D
    next_cycle();
    clear_inputs();
    md_start_E = 1; md_div_E = 0;
    expect_out("mult_start", 0, 0, 0, 0, 0, 0, 0); sample();
    next_cycle();
    md_start_E = 0;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("mult_busy%0d", i), 0, 0, 0, 0, 0, 0, 1); sample();
      next_cycle();
    end
    expect_out("mult_done", 0, 0, 0, 0, 0, 0, 0); sample();

    // div with mflo waiting in D
    next_cycle();
    md_D = 1; md_start_E = 1; md_div_E = 1;
    expect_out("div_start", 0, 0, 0, 0, 0, 1, 0); sample();
    next_cycle();
    md_start_E = 0;
    for (int i = 0; i < 10; i++) begin
      expect_out($sformatf("div_busy%0d", i), 0, 0, 0, 0, 0, 1, 1); sample();
      next_cycle();
    end
    expect_out("div_done", 0, 0, 0, 0, 0, 0, 0); sample();

    // asynchronous reset in the middle of a divide
    next_cycle();
    md_start_E = 1; md_div_E = 1;
    expect_out("div2_start", 0, 0, 0, 0, 0, 1, 0); sample();
    next_cycle();
    md_start_E = 0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("div2_busy%0d", i), 0, 0, 0, 0, 0, 1, 1); sample();
      next_cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst_mid_div", 0, 0, 0, 0, 0, 0, 0); pop_check();
    #1 rst_n = 1'b1;
    next_cycle();
    expect_out("after_rst", 0, 0, 0, 0, 0, 0, 0); sample();

    // store data forwarding in M
    next_cycle();
    clear_inputs();
    rt_M = 5; a3_W = 5; res_W = R_PC;
    expect_out("dm_pc", 0, 0, 0, 0, 3, 0, 0); sample();
    next_cycle();
    res_W = R_DM;
    expect_out("dm_dm", 0, 0, 0, 0, 2, 0, 0); sample();
    next_cycle();
    res_W = R_ALU;
    expect_out("dm_alu", 0, 0, 0, 0, 1, 0, 0); sample();
    next_cycle();
    rt_M = 0; a3_W = 0;
    expect_out("dm_zero", 0, 0, 0, 0, 0, 0, 0); sample();

    // data and MD stall together, then M-stage producer stall
    next_cycle();
    md_D = 1; md_start_E = 1; md_div_E = 0; a3_E = 9; tnew_E = 2; rs_D = 9;
    expect_out("both_stall", 0, 0, 0, 0, 0, 1, 0); sample();
    next_cycle();
    clear_inputs();
    rt_D = 7; tuse_rt_D = 0; a3_M = 7; tnew_M = 1; res_M = R_DM;
    expect_out("m_stall_rt", 0, 0, 0, 0, 0, 1, 1); sample();

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
